// File: rtl/poly_pkg.sv
// Shared definitions for the polynomial unit: ring constants, butterfly
// mode encodings and the transform controller's state type.
package poly_pkg;

    localparam int N          = 256;
    localparam int Q          = 3329;
    localparam int NTT_LAYERS = 7;

    // Butterfly mode encodings carried on sel
    localparam logic [1:0] MODE_NTT  = 2'd0;
    localparam logic [1:0] MODE_INTT = 2'd1;
    localparam logic [1:0] MODE_BYP  = 2'd2;
    localparam logic [1:0] MODE_ILL  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ntt_ctrl_wr_dly.sv
// Fixed-depth shift register that carries {valid, addr0, addr1} of each
// issued pair until its butterfly result is ready to be written back.
module wr_dly #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift one stage per cycle; clear drops every tracked pair
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/ntt_ctrl.sv
// Transform sequencer: walks the NTT, INTT or bypass pair schedule over the
// coefficient RAM, issuing one read pair plus twiddle index per cycle and
// writing each result back in place after the fixed read+butterfly latency.
module ntt_ctrl
    import poly_pkg::*;
#(
    parameter int AWID   = 8,
    parameter int KWID   = 7,
    parameter int SELWID = 2,
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SELWID-1:0] mode,
    output logic              busy,
    output logic              done,
    output logic [SELWID-1:0] sel,
    output logic              re,
    output logic [AWID-1:0]   ra0,
    output logic [AWID-1:0]   ra1,
    output logic [KWID-1:0]   widx,
    output logic              we,
    output logic [AWID-1:0]   wa0,
    output logic [AWID-1:0]   wa1
);

    localparam int L     = RD_LAT + BF_LAT;
    localparam int LWID  = 3;
    localparam int DWID  = $clog2(L + 1);
    localparam int PWID  = AWID - 1;
    localparam int DLW   = 1 + 2 * AWID;
    localparam int GENW  = 2 * AWID + KWID;

    localparam logic [AWID-1:0] ONE_A  = {{(AWID-1){1'b0}}, 1'b1};
    localparam logic [AWID-1:0] HALF_A = ONE_A << (AWID - 1);
    localparam logic [LWID-1:0] TOP_L  = LWID'(AWID - 2);

    state_t              state_r;
    logic [SELWID-1:0]   mode_r;
    logic [LWID-1:0]     l_r;
    logic [PWID-1:0]     p_r;
    logic [DWID-1:0]     dcnt_r;
    logic [DLW-1:0]      dly_in_s;
    logic [DLW-1:0]      dly_out_s;
    logic [LWID-1:0]     last_l_s;

    // Pair address / twiddle index for layer l, pair p of the given mode.
    // Block length is a power of two, so the pair's first address is p with
    // a zero bit inserted at position log2(len).
    function automatic logic [GENW-1:0] gen_addr(
        input logic [SELWID-1:0] m,
        input logic [LWID-1:0]   l,
        input logic [PWID-1:0]   p
    );
        logic [AWID-1:0] p_ext;
        logic [AWID-1:0] len;
        logic [AWID-1:0] mask;
        logic [AWID-1:0] grp;
        logic [AWID-1:0] a0;
        logic [AWID-1:0] a1;
        logic [KWID-1:0] w;
        logic [LWID-1:0] sh;
        p_ext = {1'b0, p};
        if (m == MODE_INTT) begin
            sh = l + 3'd1;
        end else begin
            sh = LWID'(AWID - 1) - l;
        end
        len  = ONE_A << sh;
        mask = len - ONE_A;
        grp  = p_ext >> sh;
        a0   = ((p_ext & ~mask) << 1) | (p_ext & mask);
        a1   = a0 | len;
        case (m)
            MODE_NTT:  w = KWID'((ONE_A << l) + grp);
            MODE_INTT: w = KWID'((HALF_A >> l) - ONE_A - grp);
            MODE_BYP: begin
                a0 = p_ext;
                a1 = p_ext | HALF_A;
                w  = {KWID{1'b0}};
            end
            default: begin
                a0 = {AWID{1'b0}};
                a1 = {AWID{1'b0}};
                w  = {KWID{1'b0}};
            end
        endcase
        return {a0, a1, w};
    endfunction

    // Bypass is a single pass; the transforms run every layer
    always_comb begin
        if (mode_r == MODE_BYP) begin
            last_l_s = {LWID{1'b0}};
        end else begin
            last_l_s = TOP_L;
        end
    end

    // Sequencer FSM with registered issue-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            mode_r  <= {SELWID{1'b0}};
            l_r     <= {LWID{1'b0}};
            p_r     <= {PWID{1'b0}};
            dcnt_r  <= {DWID{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            sel     <= {SELWID{1'b0}};
            re      <= 1'b0;
            ra0     <= {AWID{1'b0}};
            ra1     <= {AWID{1'b0}};
            widx    <= {KWID{1'b0}};
        end else begin
            re   <= 1'b0;
            ra0  <= {AWID{1'b0}};
            ra1  <= {AWID{1'b0}};
            widx <= {KWID{1'b0}};
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start && (mode != MODE_ILL)) begin
                        state_r <= ST_ISSUE;
                        mode_r  <= mode;
                        sel     <= mode;
                        busy    <= 1'b1;
                        l_r     <= {LWID{1'b0}};
                        p_r     <= {PWID{1'b0}};
                        re      <= 1'b1;
                        {ra0, ra1, widx} <= gen_addr(mode, {LWID{1'b0}}, {PWID{1'b0}});
                    end else begin
                        busy <= 1'b0;
                        sel  <= {SELWID{1'b0}};
                    end
                end
                ST_ISSUE: begin
                    if (p_r == {PWID{1'b1}}) begin
                        state_r <= ST_DRAIN;
                        dcnt_r  <= {DWID{1'b0}};
                    end else begin
                        p_r <= p_r + 1'b1;
                        re  <= 1'b1;
                        {ra0, ra1, widx} <= gen_addr(mode_r, l_r, p_r + 1'b1);
                    end
                end
                ST_DRAIN: begin
                    if (dcnt_r == DWID'(L - 1)) begin
                        if (l_r == last_l_s) begin
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r <= ST_ISSUE;
                            l_r     <= l_r + 1'b1;
                            p_r     <= {PWID{1'b0}};
                            re      <= 1'b1;
                            {ra0, ra1, widx} <= gen_addr(mode_r, l_r + 1'b1, {PWID{1'b0}});
                        end
                    end else begin
                        dcnt_r <= dcnt_r + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    sel     <= {SELWID{1'b0}};
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    sel     <= {SELWID{1'b0}};
                end
            endcase
        end
    end

    assign dly_in_s = {re, ra0, ra1};

    wr_dly #(
        .DEPTH (L),
        .WIDTH (DLW)
    ) u_wr_dly (
        .clk  (clk),
        .clr  (rst),
        .din  (dly_in_s),
        .dout (dly_out_s)
    );

    assign we  = dly_out_s[DLW-1];
    assign wa0 = dly_out_s[2*AWID-1:AWID];
    assign wa1 = dly_out_s[AWID-1:0];

endmodule

// File: tb/tb_ntt_ctrl.sv
// Scoreboard bench for ntt_ctrl: a loop-level reference of the Kyber pair
// schedule queues the expected reads; a monitor models the RAM and butterfly
// and checks every read, write, busy, sel and done against the queues.
module tb_ntt_ctrl;

    localparam int L  = 5;
    localparam int LY = 128 + L;
    localparam int Q  = 3329;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic       busy, done, re, we;
    logic [1:0] sel;
    logic [7:0] ra0, ra1, wa0, wa1;
    logic [6:0] widx;

    ntt_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy),
        .done(done), .sel(sel), .re(re), .ra0(ra0), .ra1(ra1), .widx(widx),
        .we(we), .wa0(wa0), .wa1(wa1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int a0; int a1; int w; int cy; } rd_t;
    typedef struct { int a0; int a1; int c; int d; int cy; } wr_t;
    rd_t exp_rd[$];
    wr_t exp_wr[$];

    int ram [256];
    int gold [256];
    int zetas [128];
    int log_a0 [896];
    int log_a1 [896];
    int log_w [896];
    int rd_n;
    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;
    bit run_active = 1'b0;
    int run_start = 0;
    int run_done = 0;
    int run_mode = 0;
    bit done_seen;
    int done_cyc;

    function automatic int md(input int x);
        return ((x % Q) + Q) % Q;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference schedule and golden result, written as the textbook loops
    task automatic plan_op(input int m, input int t);
        int len, k, p, z, u, v;
        exp_rd.delete();
        exp_wr.delete();
        for (int i = 0; i < 256; i++) gold[i] = ram[i];
        if (m == 2) begin
            for (int i = 0; i < 128; i++) exp_rd.push_back('{i, i + 128, 0, t + 1 + i});
            run_done = t + 1 + LY;
        end else begin
            for (int l = 0; l < 7; l++) begin
                len = (m == 0) ? (128 >> l) : (2 << l);
                k   = (m == 0) ? (1 << l) : ((128 >> l) - 1);
                p   = 0;
                for (int s = 0; s < 256; s += 2 * len) begin
                    z = zetas[k];
                    for (int j = s; j < s + len; j++) begin
                        exp_rd.push_back('{j, j + len, k, t + 1 + l * LY + p});
                        p++;
                        u = gold[j];
                        v = gold[j + len];
                        if (m == 0) begin
                            v = md(z * v);
                            gold[j] = md(u + v);
                            gold[j + len] = md(u - v);
                        end else begin
                            gold[j] = md(u + v);
                            gold[j + len] = md(z * (v - u));
                        end
                    end
                    k = (m == 0) ? k + 1 : k - 1;
                end
            end
            run_done = t + 1 + 7 * LY;
        end
    endtask

    // Monitor: RAM + butterfly model, scoreboard pops, per-cycle status checks
    always @(negedge clk) begin
        rd_t e;
        wr_t w;
        int a, b, z, c, d;
        bit eb;
        if (mon_en) begin
            if (we) begin
                if (exp_wr.size() == 0) begin
                    chk("spurious_we", 1, 0);
                end else begin
                    w = exp_wr.pop_front();
                    chk("wa0", int'(wa0), w.a0);
                    chk("wa1", int'(wa1), w.a1);
                    chk("we_cycle", cyc, w.cy);
                    ram[wa0] = w.c;
                    ram[wa1] = w.d;
                end
            end
            if (re) begin
                if (exp_rd.size() == 0) begin
                    chk("spurious_re", 1, 0);
                end else begin
                    e = exp_rd.pop_front();
                    chk("ra0", int'(ra0), e.a0);
                    chk("ra1", int'(ra1), e.a1);
                    chk("widx", int'(widx), e.w);
                    chk("re_cycle", cyc, e.cy);
                    a = ram[ra0];
                    b = ram[ra1];
                    z = zetas[widx];
                    case (sel)
                        2'd0: begin c = md(a + z * b); d = md(a - z * b); end
                        2'd1: begin c = md(a + b); d = md(z * (b - a)); end
                        default: begin c = a; d = b; end
                    endcase
                    exp_wr.push_back('{e.a0, e.a1, c, d, cyc + L});
                    if (rd_n < 896) begin
                        log_a0[rd_n] = ra0;
                        log_a1[rd_n] = ra1;
                        log_w[rd_n] = widx;
                    end
                    rd_n++;
                end
            end
            eb = run_active && (cyc >= run_start + 1) && (cyc <= run_done);
            chk("busy", int'(busy), int'(eb));
            chk("sel", int'(sel), eb ? run_mode : 0);
            chk("done", int'(done), int'(run_active && cyc == run_done));
            if (done) begin
                done_seen = 1'b1;
                done_cyc = cyc;
            end
        end
    end

    task automatic spot(input string name, input int idx, input int a0, input int a1, input int w);
        chk({name, "_ra0"}, log_a0[idx], a0);
        chk({name, "_ra1"}, log_a1[idx], a1);
        chk({name, "_widx"}, log_w[idx], w);
    endtask

    // One operation: optional start pokes while busy / on done, optional reset
    task automatic run_op(input int m, input bit poke_busy, input bit poke_done, input int rst_at);
        int t, mm;
        for (int i = 0; i < 256; i++) ram[i] = $urandom_range(Q - 1);
        t = cyc;
        plan_op(m, t);
        rd_n = 0;
        done_seen = 1'b0;
        done_cyc = -1;
        run_start = t;
        run_mode = m;
        run_active = 1'b1;
        start = 1'b1;
        mode = 2'(m);
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk);
            #2;
            start = 1'b0;
            if (rst_at >= 0 && cyc == t + rst_at) begin
                rst = 1'b1;
                @(posedge clk);
                #2;
                run_active = 1'b0;
                exp_rd.delete();
                exp_wr.delete();
                chk("rst_re", int'(re), 0);
                chk("rst_we", int'(we), 0);
                chk("rst_busy", int'(busy), 0);
                rst = 1'b0;
                repeat (10) @(posedge clk);
                #2;
                return;
            end
            if (poke_busy && cyc < run_done - 1 && $urandom_range(15) == 0) begin
                start = 1'b1;
                mode = 2'($urandom_range(3));
            end
            if (poke_done && cyc == run_done) begin
                start = 1'b1;
                mode = 2'd0;
            end
            if (cyc >= run_done + 3) break;
        end
        start = 1'b0;
        chk("done_seen", int'(done_seen), 1);
        chk("done_latency", done_cyc - t, (m == 2) ? 134 : 932);
        chk("rd_queue_empty", exp_rd.size(), 0);
        chk("wr_queue_empty", exp_wr.size(), 0);
        mm = 0;
        for (int i = 0; i < 256; i++) if (ram[i] != gold[i]) mm++;
        chk("ram_vs_golden_mismatches", mm, 0);
        run_active = 1'b0;
    endtask

    initial begin
        int e, acc, br;
        for (int i = 0; i < 128; i++) begin
            br = 0;
            for (int b = 0; b < 7; b++) if (((i >> b) & 1) != 0) br |= 1 << (6 - b);
            acc = 1;
            for (e = 0; e < br; e++) acc = (acc * 17) % Q;
            zetas[i] = acc;
        end

        rst = 1'b1;
        start = 1'b0;
        mode = 2'd0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        chk("reset_re", int'(re), 0);
        chk("reset_we", int'(we), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_sel", int'(sel), 0);
        chk("reset_addr", int'({ra0, ra1, widx, wa0, wa1}), 0);
        mon_en = 1'b1;

        // Illegal mode must never start
        start = 1'b1;
        mode = 2'd3;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        chk("illegal_mode_busy", int'(busy), 0);

        // NTT with ignored start pulses while busy
        run_op(0, 1'b1, 1'b0, -1);
        spot("ntt_l0p0", 0, 0, 128, 1);
        spot("ntt_l1p64", 128 + 64, 128, 192, 3);
        spot("ntt_l6p126", 6 * 128 + 126, 252, 254, 127);
        spot("ntt_l6p127", 6 * 128 + 127, 253, 255, 127);

        // INTT with a start coincident with done
        run_op(1, 1'b0, 1'b1, -1);
        spot("intt_l0p0", 0, 0, 2, 127);
        spot("intt_l6p0", 6 * 128, 0, 128, 1);
        repeat (5) @(posedge clk);
        #2;
        chk("start_on_done_ignored", int'(busy), 0);

        // Bypass leaves RAM unchanged
        run_op(2, 1'b0, 1'b0, -1);

        // Reset mid-issue of layer 3, then a fresh run
        run_op(0, 1'b1, 1'b0, 1 + 3 * LY + 50);
        run_op(1, 1'b0, 1'b0, -1);
        run_op(0, 1'b0, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
